// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled step generator driving shift-left,
// shift-right, bounce and binary-count patterns on an LED bus.
// Build option: define LED_SEQ_BOUNCE_EN to include the bounce pattern
// (mode 2); without it mode 2 runs the shift-left pattern and no
// direction register exists.
module led_sequencer #(
   parameter int unsigned LED_W    = 8,
   parameter int unsigned TICK_DIV = 50000000
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             enable,
   input  logic [1:0]       mode,
   output logic [LED_W-1:0] LED,
   output logic             tick,
   output logic             wrap
);

   localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      MODE_SHL    = 2'd0,
      MODE_SHR    = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_COUNT  = 2'd3
   } mode_e;

`ifdef LED_SEQ_BOUNCE_EN
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   dir_e dir_q, dir_d;
`endif

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LED_W-1:0] led_q, led_d;
   logic             tick_q, tick_d;
   logic             wrap_q, wrap_d;
   mode_e            mode_q, mode_d;
   mode_e            mode_in;
   logic             step;

   assign mode_in = mode_e'(mode);

   // Initial pattern shown when a mode is entered (reset or mode change).
   function automatic logic [LED_W-1:0] start_pattern(input mode_e m);
      logic [LED_W-1:0] p;
      p = '0;
      case (m)
         MODE_SHR:   p[LED_W-1] = 1'b1;
         MODE_COUNT: p          = '0;
         default:    p[0]       = 1'b1;
      endcase
      return p;
   endfunction

   assign step = enable && (cnt_q == CNT_MAX);

   // Next-state: mode change beats a step; enable gates prescaler and pattern.
   always_comb begin
      cnt_d  = cnt_q;
      led_d  = led_q;
      tick_d = 1'b0;
      wrap_d = 1'b0;
      mode_d = mode_q;
`ifdef LED_SEQ_BOUNCE_EN
      dir_d  = dir_q;
`endif
      if (mode_in != mode_q) begin
         led_d  = start_pattern(mode_in);
         cnt_d  = '0;
         mode_d = mode_in;
`ifdef LED_SEQ_BOUNCE_EN
         dir_d  = DIR_UP;
`endif
      end else if (step) begin
         cnt_d  = '0;
         tick_d = 1'b1;
         case (mode_q)
`ifdef LED_SEQ_BOUNCE_EN
            MODE_BOUNCE: begin
               if (dir_q == DIR_UP) begin
                  led_d = led_q << 1;
                  if (led_q[LED_W-2]) dir_d = DIR_DOWN;
               end else begin
                  led_d = led_q >> 1;
                  if (led_q[1]) begin
                     wrap_d = 1'b1;
                     dir_d  = DIR_UP;
                  end
               end
            end
            MODE_SHL: begin
               led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
               wrap_d = led_q[LED_W-1];
            end
`else
            MODE_SHL, MODE_BOUNCE: begin
               led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
               wrap_d = led_q[LED_W-1];
            end
`endif
            MODE_SHR: begin
               led_d  = {led_q[0], led_q[LED_W-1:1]};
               wrap_d = led_q[0];
            end
            MODE_COUNT: begin
               led_d  = led_q + 1'b1;
               wrap_d = &led_q;
            end
            default: led_d = led_q;
         endcase
      end else if (enable) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State and registered outputs; reset loads the sampled mode's start pattern.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cnt_q  <= '0;
         led_q  <= start_pattern(mode_in);
         tick_q <= 1'b0;
         wrap_q <= 1'b0;
         mode_q <= mode_in;
`ifdef LED_SEQ_BOUNCE_EN
         dir_q  <= DIR_UP;
`endif
      end else begin
         cnt_q  <= cnt_d;
         led_q  <= led_d;
         tick_q <= tick_d;
         wrap_q <= wrap_d;
         mode_q <= mode_d;
`ifdef LED_SEQ_BOUNCE_EN
         dir_q  <= dir_d;
`endif
      end
   end

   assign LED  = led_q;
   assign tick = tick_q;
   assign wrap = wrap_q;

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 Parameter LED_W, default 8: LED output width; legal range 2..32.
REQ-002 Parameter TICK_DIV, default 50000000: CLOCK_50 cycles per pattern step; legal range 1..2^31-1.
REQ-003 Port CLOCK_50  input  1  sole clock, all state on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port enable  input  1  high = prescaler runs; low = prescaler, pattern and direction frozen.
REQ-006 Port mode  input  2  pattern select: 0 shift-left, 1 shift-right, 2 bounce, 3 binary count.
REQ-007 Port LED  output  LED_W  current pattern, registered.
REQ-008 Port tick  output  1  one-cycle pulse, registered, coincident with each LED step.
REQ-009 Port wrap  output  1  one-cycle pulse, registered, coincident with the step that completes a pattern cycle.

Function
REQ-010 Prescaler counter SHALL be $clog2(TICK_DIV) bits (min 1), counting 0..TICK_DIV-1 while enable=1.
REQ-011 When the counter equals TICK_DIV-1 with enable=1, the counter SHALL return to 0 and one step SHALL occur at that edge.
REQ-012 TICK_DIV=1: a step SHALL occur on every enabled cycle.
REQ-013 A step SHALL update LED and set tick=1 for exactly that cycle; tick=0 otherwise.
REQ-014 Mode 0: start pattern = bit 0 set; step = shift left by 1; MSB -> bit 0 with wrap=1.
REQ-015 Mode 1: start pattern = bit LED_W-1 set; step = shift right by 1; bit 0 -> MSB with wrap=1.
REQ-016 Mode 2: start = bit 0, direction up; shift left until MSB, then direction down, shift right until bit 0, then direction up; wrap=1 on the step landing on bit 0; MSB and bit 0 each shown for exactly one step per traversal (period 2*LED_W-2 steps).
REQ-017 Mode 3: start = all zeros; step = LED+1 modulo 2^LED_W; wrap=1 on the all-ones -> zero step.
REQ-018 A registered copy mode_q SHALL track mode; when mode != mode_q, the block SHALL at that edge load the new mode's start pattern, clear the prescaler, set direction up, set mode_q=mode and drive tick=0, wrap=0.
REQ-019 A mode change SHALL take priority over a step on the same edge; the step is discarded.
REQ-020 A mode change SHALL be honoured regardless of enable.
REQ-021 wrap SHALL never assert without tick on the same cycle.

Reset
REQ-022 With reset=1 at a rising edge: prescaler=0, tick=0, wrap=0, direction=up, mode_q=mode, LED = start pattern of the sampled mode.
REQ-023 Reset SHALL override enable, step and mode change; reset mid-sequence SHALL abandon the pattern with no wrap pulse.
REQ-024 First step after reset release SHALL occur TICK_DIV enabled cycles after the first enabled edge with reset=0.

Configuration
REQ-025 Macro LED_SEQ_BOUNCE_EN SHALL control mode 2 inclusion.
REQ-026 With LED_SEQ_BOUNCE_EN defined: mode 2 behaves per REQ-016.
REQ-027 Without it: no direction register is synthesised and mode 2 SHALL behave identically to mode 0.

Verification (LED_W=8, TICK_DIV=4 unless stated)
REQ-028 Reset with mode=0, enable=1, hold 12 cycles -> LED 0x01, then 0x02 on cycle 4, 0x04 on cycle 8, 0x08 on cycle 12; tick pulses only on those cycles.
REQ-029 Mode 0 run 32 steps -> LED 0x80 followed by 0x01 with wrap=1 on that one step only; mode 1 run -> 0x80, 0x40 ... 0x01, 0x80 with wrap=1.
REQ-030 Mode 2, macro defined, 16 steps -> 0x01,0x02...0x80,0x40...0x01; wrap=1 at 14th step only; macro undefined -> identical to mode 0 sequence.
REQ-031 Mode 3 from reset, 256 steps -> LED 0xFF then 0x00 with wrap=1; enable=0 for 10 cycles mid-count -> LED, tick and prescaler frozen, resumes with remaining count.
REQ-032 Change mode 0->1 on the same edge the prescaler reaches 3 -> LED=0x80, tick=0, wrap=0, next step 4 cycles later to 0x40.
REQ-033 TICK_DIV=1, mode 3, assert reset while LED=0x05 -> next cycle LED=0x00, tick=0; steps resume every cycle after release.
